tia_horizontal_counter: RTL and testbench
=========================================

TIA_HORIZONTAL_COUNTER -- requirements
Module: tia_horizontal_counter

Interface
REQ-001 SHALL have a parameter LINE_COUNTS, default 57: counts per scan line. Each count is 4 colour clocks, giving 228 colour clocks per line.
REQ-002 SHALL have these ports:
  clk  in  1  single clock; all state updates on rising edge
  r  in  1  reset, synchronous, active-high
  phi1  in  1  biphase clock phase 1 level, synchronous to clk
  phi2  in  1  biphase clock phase 2 level, synchronous to clk
  rl  in  1  latched reset from biphase clock; holds the line counter
  wsync_req  in  1  1-clk pulse: halt CPU until the next line start
  rsync_req  in  1  1-clk pulse: restart the line counter
  hmove_req  in  1  1-clk pulse: extend the next line's blank
  hcount  out  6  current count, 0..LINE_COUNTS-1
  hsync  out  1  horizontal sync
  hblank  out  1  horizontal blank
  rdy  out  1  CPU ready; low = halted
  line_start  out  1  1-clk pulse when the line begins
  phase_err  out  1  sticky: phi1 and phi2 were high together

Function
REQ-003 An advance SHALL occur on any clk edge where phi2=1 and the registered previous phi2=0 (phi2 rising), rl=0 and r=0.
REQ-004 In steady biphase operation, advances SHALL occur exactly once per 4 clk.
REQ-005 On an advance, hcount SHALL become hcount+1; from LINE_COUNTS-1 it SHALL wrap to 0.
REQ-006 On an advance with a pending rsync (REQ-011), hcount SHALL become 0 regardless of its current value.
REQ-007 line_start SHALL be 1 for exactly the clk cycle following any advance that sets hcount to 0, by wrap or rsync; otherwise 0.
REQ-008 While rl=1, hcount SHALL be forced to 0 and line_start SHALL stay 0; pending wsync, rsync and hmove SHALL be retained.
REQ-009 hsync SHALL be registered and equal 1 exactly while hcount is in 4..7 inclusive.
REQ-010 hblank SHALL be registered and equal 1 exactly while hcount is in 0..16 inclusive, or in 0..17 when hmove_active=1.
REQ-011 rsync_req SHALL set an rsync-pending flag; the flag SHALL clear on the advance that consumes it; repeat pulses before consumption SHALL have no further effect.
REQ-012 hmove_req SHALL set an hmove-pending flag at any count.
REQ-013 On an advance into hcount=0, hmove_active SHALL load the hmove-pending flag and hmove-pending SHALL clear.
REQ-014 hmove_active SHALL clear on the advance out of count 17.
REQ-015 hmove_req arriving on the same edge as the advance into 0 SHALL remain pending for the following line.
REQ-016 wsync_req with rdy=1 SHALL drive rdy to 0 on the next clk edge.
REQ-017 rdy SHALL return to 1 on the same edge on which line_start becomes 1.
REQ-018 wsync_req while rdy=0 SHALL be ignored.
REQ-019 wsync_req on the same edge as an advance into 0 SHALL take priority: rdy goes to 0 and is held until the following line start.
REQ-020 phase_err SHALL set when phi1=1 and phi2=1 are sampled on the same edge, and SHALL remain 1 until r.
REQ-021 A phase_err condition SHALL NOT block advances.
REQ-022 All outputs SHALL be registered; no output SHALL depend combinationally on inputs.

Reset
REQ-023 While r=1 at a clk edge, the block SHALL set: hcount=0, hsync=0, hblank=1, rdy=1, line_start=0, phase_err=0, and clear all pending and active flags and the previous-phi2 register.
REQ-024 r SHALL take priority over every other input.
REQ-025 r asserted mid-line or while rdy=0 SHALL restore the REQ-023 values on the next edge.
REQ-026 The first phi2 rise after r deasserts (with rl=0) SHALL advance hcount from 0 to 1.

Verification
REQ-027 Free run: drive r, then run the biphase sequence phi1, idle, phi2, idle, 1 clk each, for 300 phi2 rises.
  -> hcount visits 0..56 in order and wraps.
  -> line_start pulses every 228 clk.
  -> hsync is high 16 clk per line, hblank high 68 clk per line, phase_err stays 0.
REQ-028 WSYNC: pulse wsync_req at hcount=30.
  -> rdy is 0 from the next edge until line_start rises, with both changing on the same edge.
  -> A second wsync_req at hcount=40 causes no change.
REQ-029 RSYNC: pulse rsync_req at hcount=20.
  -> The next advance gives hcount=0 with line_start=1 and rdy=1.
  -> The following advance gives hcount=1.
REQ-030 HMOVE: pulse hmove_req at hcount=50.
  -> On the next line, hblank is 1 through count 17 (72 clk).
  -> On the line after that, hblank returns to ending after count 16.
REQ-031 Phase overlap and rl hold:
  -> Force phi1=phi2=1 for one clk: phase_err=1 and it stays 1 until r.
  -> Hold rl=1 for 20 clk at hcount=10: hcount=0 throughout with no line_start.
  -> Release rl: counting resumes from 1.
REQ-032 Reset mid-operation: assert r at hcount=45 with rdy=0 and hmove pending.
  -> All REQ-023 values appear on the next edge.
  -> The next line shows no extended hblank.

Source files
------------

// File: rtl/tia_horizontal_counter.sv
// Horizontal line counter for a TIA-style video chip: counts biphase phi2 rises,
// derives registered sync/blank, and manages WSYNC/RSYNC/HMOVE requests.
module tia_horizontal_counter #(
  parameter int unsigned LINE_COUNTS = 57
) (
  input  logic       clk,
  input  logic       r,
  input  logic       phi1,
  input  logic       phi2,
  input  logic       rl,
  input  logic       wsync_req,
  input  logic       rsync_req,
  input  logic       hmove_req,
  output logic [5:0] hcount,
  output logic       hsync,
  output logic       hblank,
  output logic       rdy,
  output logic       line_start,
  output logic       phase_err
);

  localparam logic [5:0] LAST = 6'(LINE_COUNTS - 1);

  logic [5:0] hcount_q, hcount_d;
  logic       phi2_prev_q;
  logic       rsync_pend_q, rsync_pend_d;
  logic       hmove_pend_q, hmove_pend_d;
  logic       hmove_act_q, hmove_act_d;
  logic       rdy_q, rdy_d;
  logic       line_start_q, line_start_d;
  logic       phase_err_q, phase_err_d;
  logic       hsync_q, hsync_d;
  logic       hblank_q, hblank_d;
  logic       adv, wrap;

  always_comb begin
    adv  = phi2 & ~phi2_prev_q & ~rl;
    wrap = adv & (rsync_pend_q | (hcount_q == LAST));

    hcount_d = hcount_q;
    if (rl || wrap)
      hcount_d = '0;
    else if (adv)
      hcount_d = hcount_q + 6'd1;

    rsync_pend_d = (rsync_pend_q & ~adv) | rsync_req;
    // a request landing on the wrap edge survives into the next line
    hmove_pend_d = (hmove_pend_q & ~wrap) | hmove_req;

    hmove_act_d = hmove_act_q;
    if (wrap)
      hmove_act_d = hmove_pend_q;
    else if (adv && hcount_q == 6'd17)
      hmove_act_d = 1'b0;

    rdy_d = rdy_q;
    if (wsync_req && rdy_q)
      rdy_d = 1'b0;
    else if (wrap)
      rdy_d = 1'b1;

    line_start_d = wrap;
    phase_err_d  = phase_err_q | (phi1 & phi2);

    // decoded from next count so the registered outputs line up with hcount
    hsync_d  = (hcount_d >= 6'd4) && (hcount_d <= 6'd7);
    hblank_d = hcount_d <= (hmove_act_d ? 6'd17 : 6'd16);
  end

  always_ff @(posedge clk) begin
    if (r) begin
      hcount_q     <= '0;
      phi2_prev_q  <= 1'b0;
      rsync_pend_q <= 1'b0;
      hmove_pend_q <= 1'b0;
      hmove_act_q  <= 1'b0;
      rdy_q        <= 1'b1;
      line_start_q <= 1'b0;
      phase_err_q  <= 1'b0;
      hsync_q      <= 1'b0;
      hblank_q     <= 1'b1;
    end else begin
      hcount_q     <= hcount_d;
      phi2_prev_q  <= phi2;
      rsync_pend_q <= rsync_pend_d;
      hmove_pend_q <= hmove_pend_d;
      hmove_act_q  <= hmove_act_d;
      rdy_q        <= rdy_d;
      line_start_q <= line_start_d;
      phase_err_q  <= phase_err_d;
      hsync_q      <= hsync_d;
      hblank_q     <= hblank_d;
    end
  end

  assign hcount     = hcount_q;
  assign hsync      = hsync_q;
  assign hblank     = hblank_q;
  assign rdy        = rdy_q;
  assign line_start = line_start_q;
  assign phase_err  = phase_err_q;

endmodule

// File: tb/tb_tia_horizontal_counter.sv
// Bench for tia_horizontal_counter: directed scenarios plus random pulses,
// checked every cycle against a behavioural line model.
module tb_tia_horizontal_counter;

  localparam int LC = 57;

  logic       clk = 1'b0;
  logic       r = 1'b0, phi1 = 1'b0, phi2 = 1'b0, rl = 1'b0;
  logic       wsync_req = 1'b0, rsync_req = 1'b0, hmove_req = 1'b0;
  logic [5:0] hcount;
  logic       hsync, hblank, rdy, line_start, phase_err;

  tia_horizontal_counter #(.LINE_COUNTS(LC)) dut (
    .clk(clk), .r(r), .phi1(phi1), .phi2(phi2), .rl(rl),
    .wsync_req(wsync_req), .rsync_req(rsync_req), .hmove_req(hmove_req),
    .hcount(hcount), .hsync(hsync), .hblank(hblank), .rdy(rdy),
    .line_start(line_start), .phase_err(phase_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int ph = 0;

  // model state: count position, pending requests, and visible flags
  int m_cnt = 0;
  bit m_prev2, m_rs, m_hp, m_ha, m_ls, m_pe;
  bit m_rdy = 1'b1;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model(input bit rst, p1, p2, rlv, ws, rs, hm);
    bit adv, newline, leave17;
    if (rst) begin
      m_cnt = 0; m_prev2 = 0; m_rs = 0; m_hp = 0; m_ha = 0;
      m_ls = 0; m_pe = 0; m_rdy = 1;
    end else begin
      adv     = p2 && !m_prev2 && !rlv;
      newline = adv && (m_rs || m_cnt == LC - 1);
      leave17 = adv && m_cnt == 17;
      if (ws && m_rdy) m_rdy = 0;
      else if (newline) m_rdy = 1;
      if (newline) begin m_ha = m_hp; m_hp = 0; end
      else if (leave17) m_ha = 0;
      if (hm) m_hp = 1;
      if (adv) m_rs = 0;
      if (rs) m_rs = 1;
      if (rlv || newline) m_cnt = 0;
      else if (adv) m_cnt = (m_cnt + 1) % LC;
      m_ls = newline;
      m_pe = m_pe || (p1 && p2);
      m_prev2 = p2;
    end
  endtask

  task automatic cyc(input bit rst, ws, rs, hm, rlv, ovl);
    r = rst; rl = rlv; wsync_req = ws; rsync_req = rs; hmove_req = hm;
    phi1 = (ph == 0) || ovl;
    phi2 = (ph == 2) || ovl;
    @(posedge clk);
    model(rst, phi1, phi2, rlv, ws, rs, hm);
    #1;
    check("hcount", int'(hcount), m_cnt);
    check("hsync", int'(hsync), int'(m_cnt >= 4 && m_cnt <= 7));
    check("hblank", int'(hblank), int'(m_cnt <= (m_ha ? 17 : 16)));
    check("rdy", int'(rdy), int'(m_rdy));
    check("line_start", int'(line_start), int'(m_ls));
    check("phase_err", int'(phase_err), int'(m_pe));
    wsync_req = 0; rsync_req = 0; hmove_req = 0;
    ph = (ph + 1) % 4;
  endtask

  task automatic run_until(input int target);
    int n = 0;
    while (m_cnt != target && n < 1000) begin
      cyc(0, 0, 0, 0, 0, 0);
      n++;
    end
    check("wait_count", m_cnt, target);
  endtask

  task automatic run_until_ls();
    int n = 0;
    do begin
      cyc(0, 0, 0, 0, 0, 0);
      n++;
    end while (!m_ls && n < 1000);
    check("wait_line_start", int'(m_ls), 1);
  endtask

  task automatic line_blank(output int hb);
    hb = int'(hblank);
    for (int i = 1; i < 4 * LC; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      hb += int'(hblank);
    end
  endtask

  initial begin
    int since, hs_n, hb_n, hb, rl_left;
    bit started, ws, rs, hm, ov;

    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check("reset_hblank", int'(hblank), 1);

    // free run: line spacing and per-line sync/blank widths
    since = 0; hs_n = 0; hb_n = 0; started = 0;
    for (int i = 0; i < 1200; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      if (line_start) begin
        if (started) begin
          check("line_period", since, 228);
          check("hsync_width", hs_n, 16);
          check("hblank_width", hb_n, 68);
        end
        started = 1; since = 0; hs_n = 0; hb_n = 0;
      end
      since++;
      hs_n += int'(hsync);
      hb_n += int'(hblank);
    end
    check("free_lines_seen", int'(started), 1);

    // WSYNC: halt at 30, second request at 40 ignored, release on line start
    run_until(30);
    cyc(0, 1, 0, 0, 0, 0);
    check("wsync_halt", int'(rdy), 0);
    run_until(40);
    cyc(0, 1, 0, 0, 0, 0);
    check("wsync_second", int'(rdy), 0);
    run_until_ls();
    check("wsync_release", int'(rdy), 1);

    // RSYNC at 20 restarts the line on the next advance
    run_until(20);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    run_until_ls();
    check("rsync_count", int'(hcount), 0);
    check("rsync_rdy", int'(rdy), 1);
    run_until(1);
    check("rsync_next", int'(hcount), 1);

    // HMOVE at 50: next line blank 72 clk, the one after back to 68
    run_until(50);
    cyc(0, 0, 0, 1, 0, 0);
    run_until_ls();
    line_blank(hb);
    check("hmove_line", hb, 72);
    run_until_ls();
    line_blank(hb);
    check("after_hmove_line", hb, 68);

    // random pulses, rl holds and phase overlaps
    rl_left = 0;
    for (int i = 0; i < 4000; i++) begin
      ws = ($urandom_range(0, 59) == 0);
      rs = ($urandom_range(0, 149) == 0);
      hm = ($urandom_range(0, 79) == 0);
      ov = ($urandom_range(0, 699) == 0);
      if (rl_left == 0 && $urandom_range(0, 299) == 0)
        rl_left = int'($urandom_range(1, 30));
      cyc(0, ws, rs, hm, rl_left > 0, ov);
      if (rl_left > 0) rl_left--;
    end

    cyc(1, 0, 0, 0, 0, 0);
    check("reset_clears_perr", int'(phase_err), 0);

    // phase overlap is sticky; rl hold at 10 then resume from 1
    run_until(3);
    cyc(0, 0, 0, 0, 0, 1);
    check("overlap_perr", int'(phase_err), 1);
    run_until(10);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 0, 1, 0);
      check("rl_hold_count", int'(hcount), 0);
      check("rl_hold_ls", int'(line_start), 0);
    end
    run_until(1);
    check("rl_resume", int'(hcount), 1);
    check("perr_sticky", int'(phase_err), 1);

    // reset at 45 with rdy low and hmove pending
    run_until(40);
    cyc(0, 1, 0, 1, 0, 0);
    run_until(45);
    check("pre_reset_rdy", int'(rdy), 0);
    cyc(1, 0, 0, 0, 0, 0);
    check("mid_reset_hcount", int'(hcount), 0);
    check("mid_reset_rdy", int'(rdy), 1);
    check("mid_reset_hblank", int'(hblank), 1);
    check("mid_reset_hsync", int'(hsync), 0);
    check("mid_reset_perr", int'(phase_err), 0);
    ph = 0;
    run_until(1);
    check("post_reset_first", int'(hcount), 1);
    run_until_ls();
    line_blank(hb);
    check("post_reset_line", hb, 68);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
